abs_pump_scheduler: RTL
=======================

// Module: abs_pump_scheduler
// PURPOSE
//  Shares the single hydraulic recovery pump and its Vrc2 release valves among N_CH per-wheel
//  ABS channels. Each wheel EFSM raises pump_req while in its release phase; this block
//  grants one channel at a time (round-robin), sequences valve-open -> pump-on -> pump-off ->
//  valve-close with settle gaps, and enforces min/max pump dwell.
//  Sits between the per-wheel ABS EFSMs and the pump/valve drivers.
// PARAMETERS
//  N_CH     4   number of wheel channels (fixed 4 in this revision)
//  GAP_CYC  4   valve settle cycles before pump-on and after pump-off (>=1)
//  MIN_ON   8   minimum pump dwell per grant, cycles (>=1)
//  MAX_ON   64  dwell after which the channel is pre-empted if another request waits (>=MIN_ON)
//  CNT_W    8   width of service counter
// PORTS
//  clk            in   1      system clock
//  reset          in   1      asynchronous, active-low reset
//  engine_status  in   1      1 = engine running; 0 aborts all activity
//  pump_req       in   N_CH   per-channel pump/release request, level
//  clr_cnt        in   1      synchronous clear of service_cnt
//  vrc2_grant     out  N_CH   one-hot (or zero) Vrc2 open command to the granted channel
//  recovery_pump  out  1      pump motor on
//  busy           out  1      state != IDLE
//  service_cnt    out  CNT_W  number of PUMP entries, saturating
// BEHAVIOUR
//  - Clock is one domain (clk); reset is asynchronous, active-low. Reset low: state=IDLE,
//    vrc2_grant=0, recovery_pump=0, busy=0, service_cnt=0, rr_last=N_CH-1, timers=0.
//  - All outputs are registered and decoded from state/sel; no combinational path from input to output.
//  - States: IDLE, SETTLE, PUMP, GAP.
//  - IDLE: grant=0, pump=0. If engine_status && |pump_req: sel = first set bit searching
//    rr_last+1, rr_last+2, ... (mod N_CH); go SETTLE, timer=GAP_CYC-1.
//  - SETTLE: grant=onehot(sel), pump=0. Decrement timer; at timer==0 go PUMP, dwell=0,
//    rr_last<=sel, service_cnt+=1 (saturates at 2^CNT_W-1).
//  - PUMP: grant=onehot(sel), pump=1. dwell increments each cycle, saturating at MAX_ON-1.
//    Exit to GAP (timer=GAP_CYC-1) when dwell>=MIN_ON-1 AND
//    (!pump_req[sel] OR (dwell==MAX_ON-1 AND |(pump_req & ~onehot(sel)))).
//    If sel stays requested with no competitor, PUMP holds indefinitely.
//  - Request drop during SETTLE: PUMP is still entered and MIN_ON served (valve already opening).
//  - GAP: grant=0, pump=0. Decrement timer; at 0 go IDLE. Requests during GAP wait.
//  - Latency: req seen in IDLE at edge k -> grant high after edge k; pump high GAP_CYC cycles
//    later; pump low -> next grant no earlier than GAP_CYC+1 cycles later.
//  - engine_status==0 (sampled): from any state, next cycle state=IDLE, grant=0, pump=0;
//    rr_last and service_cnt retained.
//  - clr_cnt and increment in same cycle: clear wins (service_cnt=0).
//  - Reset asserted mid-operation: outputs drop asynchronously to reset values.
//  - Invariant: recovery_pump=1 implies vrc2_grant is exactly one-hot; at most one bit of vrc2_grant set.
// STRUCTURE
//  - abs_pkg: state encoding (IDLE=2'b00, SETTLE=2'b01, PUMP=2'b10, GAP=2'b11), N_CH,
//    default timing constants shared with the per-wheel EFSM.
//  - Sub-module abs_rr_picker: combinational round-robin picker (req[N_CH], last[idx]) ->
//    (valid, idx). Scheduler FSM, timers and counter stay in this module.
// TESTING (defaults)
//  1 Single req ch2 held 3 cycles from reset release -> grant=4'b0100 next cycle; pump=1 after 4
//    more cycles for exactly 8 cycles; then 4 idle GAP cycles; service_cnt=1.
//  2 ch0 and ch3 held high continuously -> ch0 granted first; pump on 64 cycles, GAP, then ch3
//    for 64; alternates; grant never overlaps.
//  3 ch1 alone held 200 cycles -> pump stays on uninterrupted; drops MIN_ON-respecting on release.
//  4 engine_status=0 at dwell 10 -> next cycle grant=0, pump=0, busy=0; re-raise -> fresh SETTLE.
//  5 reset low mid-PUMP -> outputs 0 immediately (async); after release, rr_last=3 (ch0 first).
//  6 Drive 260 grants -> service_cnt stays 255; clr_cnt coincident with increment -> 0.

Source files
------------

// File: rtl/abs_pump_scheduler_pkg.sv
// Shared types and default timing for the ABS recovery-pump scheduler and the per-wheel EFSMs.
package abs_pump_scheduler_pkg;

  localparam int N_CH  = 4;
  localparam int IDX_W = 2;

  localparam int GAP_CYC_DEF = 4;
  localparam int MIN_ON_DEF  = 8;
  localparam int MAX_ON_DEF  = 64;
  localparam int CNT_W_DEF   = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETTLE = 2'b01,
    ST_PUMP   = 2'b10,
    ST_GAP    = 2'b11
  } sched_state_t;

  function automatic logic [N_CH-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/abs_pump_scheduler_if.sv
// Bundle between the wheel EFSMs (master) and the pump scheduler (slave).
interface abs_pump_scheduler_if
  import abs_pump_scheduler_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) ();

  logic             engine_status;
  logic [N_CH-1:0]  pump_req;
  logic             clr_cnt;
  logic [N_CH-1:0]  vrc2_grant;
  logic             recovery_pump;
  logic             busy;
  logic [CNT_W-1:0] service_cnt;

  modport master (
    output engine_status, pump_req, clr_cnt,
    input  vrc2_grant, recovery_pump, busy, service_cnt
  );

  modport slave (
    input  engine_status, pump_req, clr_cnt,
    output vrc2_grant, recovery_pump, busy, service_cnt
  );

endinterface

// File: rtl/abs_pump_scheduler_rr_picker.sv
// Combinational round-robin picker: first requesting channel after 'last', wrapping.
module abs_rr_picker
  import abs_pump_scheduler_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = 1; i <= N_CH; i++) begin
      cand = IDX_W'((int'(last) + i) % N_CH);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/abs_pump_scheduler.sv
// Shares one hydraulic recovery pump among the wheel channels: round-robin grant,
// valve-open -> pump-on -> pump-off -> valve-close sequencing with min/max dwell.
module abs_pump_scheduler
  import abs_pump_scheduler_pkg::*;
#(
  parameter int GAP_CYC = GAP_CYC_DEF,
  parameter int MIN_ON  = MIN_ON_DEF,
  parameter int MAX_ON  = MAX_ON_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  abs_pump_scheduler_if.slave  bus
);

  localparam int TMR_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int DWL_W = (MAX_ON > 1) ? $clog2(MAX_ON) : 1;

  sched_state_t     state;
  logic [IDX_W-1:0] sel;
  logic [IDX_W-1:0] rr_last;
  logic [TMR_W-1:0] timer;
  logic [DWL_W-1:0] dwell;
  logic [N_CH-1:0]  grant;
  logic             pump;
  logic             busy;
  logic [CNT_W-1:0] service_cnt;

  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic             min_done;
  logic             competitor;
  logic             pump_exit;
  logic             settle_done;

  abs_rr_picker u_picker (
    .req   (bus.pump_req),
    .last  (rr_last),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign min_done    = (dwell >= DWL_W'(MIN_ON - 1));
  assign competitor  = |(bus.pump_req & ~onehot(sel));
  assign pump_exit   = min_done &&
                       (!bus.pump_req[sel] || ((dwell == DWL_W'(MAX_ON - 1)) && competitor));
  assign settle_done = bus.engine_status && (state == ST_SETTLE) && (timer == '0);

  // Outputs are written together with the state they belong to, so they stay registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      sel     <= '0;
      rr_last <= IDX_W'(N_CH - 1);
      timer   <= '0;
      dwell   <= '0;
      grant   <= '0;
      pump    <= 1'b0;
      busy    <= 1'b0;
    end else if (!bus.engine_status) begin
      state <= ST_IDLE;
      grant <= '0;
      pump  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            state <= ST_SETTLE;
            sel   <= pick_idx;
            timer <= TMR_W'(GAP_CYC - 1);
            grant <= onehot(pick_idx);
            busy  <= 1'b1;
          end
        end
        ST_SETTLE: begin
          // The valve is already opening, so a dropped request still gets a full MIN_ON.
          if (timer == '0) begin
            state   <= ST_PUMP;
            dwell   <= '0;
            rr_last <= sel;
            pump    <= 1'b1;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ST_PUMP: begin
          if (pump_exit) begin
            state <= ST_GAP;
            timer <= TMR_W'(GAP_CYC - 1);
            grant <= '0;
            pump  <= 1'b0;
          end else if (dwell != DWL_W'(MAX_ON - 1)) begin
            dwell <= dwell + 1'b1;
          end
        end
        ST_GAP: begin
          if (timer == '0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          grant <= '0;
          pump  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // A coincident clear beats the increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      service_cnt <= '0;
    end else if (bus.clr_cnt) begin
      service_cnt <= '0;
    end else if (settle_done && (service_cnt != {CNT_W{1'b1}})) begin
      service_cnt <= service_cnt + 1'b1;
    end
  end

  assign bus.vrc2_grant    = grant;
  assign bus.recovery_pump = pump;
  assign bus.busy          = busy;
  assign bus.service_cnt   = service_cnt;

endmodule
